// File: rtl/loader_pkg.sv
// Shared types and default parameters for the flash-to-RAM loader.
package loader_pkg;

  localparam int unsigned RAM_AW_DEF     = 19;
  localparam int unsigned LEN_W_DEF      = 17;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned FLASH_AW       = 24;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO; push while full is dropped unless a pop frees a slot the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/flash_loader.sv
// Copies a block of bytes from the serial-flash IP into RAM through a small throttled FIFO.
module flash_loader
  import loader_pkg::*;
#(
  parameter int unsigned RAM_AW     = RAM_AW_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk32,
  input  logic                rst_n,
  input  logic                start,
  input  logic [FLASH_AW-1:0] src_addr,
  input  logic [RAM_AW-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                ld_busy,
  output logic                ld_done,
  output logic                ld_error,
  output logic [FLASH_AW-1:0] asmi_addr,
  output logic                asmi_rden,
  output logic                asmi_read,
  output logic                asmi_reset,
  input  logic                asmi_busy,
  input  logic                asmi_data_valid,
  input  logic [BYTE_W-1:0]   asmi_dataout,
  output logic                ram_req,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [BYTE_W-1:0]   ram_data,
  input  logic                ram_ack
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rx_count;
  logic [LEN_W-1:0]  wr_count;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [BYTE_W-1:0] fifo_head;

  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic              free_ok_c;
  logic [CW-1:0]     count_next_c;
  logic [LEN_W-1:0]  rx_next_c;

  // Byte acceptance and FIFO occupancy as it will be after this edge.
  always_comb begin
    accept_c     = (state == ST_STREAM) && asmi_data_valid && (rx_count < len_q);
    pop_c        = ram_ack && !fifo_empty;
    push_c       = accept_c && (!fifo_full || pop_c);
    drop_c       = accept_c && fifo_full && !pop_c;
    count_next_c = fifo_count + CW'(push_c) - CW'(pop_c);
    rx_next_c    = rx_count + LEN_W'(accept_c);
    free_ok_c    = (CW'(FIFO_DEPTH) - count_next_c) > CW'(2);
  end

  assign ram_req  = !fifo_empty;
  assign ram_data = fifo_head;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk32),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (asmi_dataout),
    .pop   (pop_c),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      rx_count   <= '0;
      wr_count   <= '0;
      asmi_addr  <= '0;
      asmi_rden  <= 1'b0;
      asmi_read  <= 1'b0;
      asmi_reset <= 1'b1;
      ram_addr   <= '0;
      ld_busy    <= 1'b0;
      ld_done    <= 1'b0;
      ld_error   <= 1'b0;
    end else begin
      ld_done   <= 1'b0;
      asmi_read <= 1'b0;
      rx_count  <= rx_next_c;
      // A dropped byte still counts as retired so DRAIN can terminate.
      wr_count  <= wr_count + LEN_W'(pop_c | drop_c);
      if (pop_c)  ram_addr <= ram_addr + RAM_AW'(1);
      if (drop_c) ld_error <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            ld_busy  <= 1'b1;
            ld_error <= 1'b0;
            if (length != '0) begin
              asmi_addr  <= src_addr;
              ram_addr   <= dst_addr;
              len_q      <= length;
              rx_count   <= '0;
              wr_count   <= '0;
              asmi_rden  <= 1'b1;
              asmi_reset <= 1'b0;
              state      <= ST_SETUP;
            end else begin
              ld_done <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_SETUP: state <= ST_CMD;
        ST_CMD: begin
          if (!asmi_busy) begin
            asmi_read <= 1'b1;
            asmi_rden <= free_ok_c && (rx_next_c < len_q);
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (rx_count == len_q) begin
            asmi_rden <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            asmi_rden <= free_ok_c && (rx_next_c < len_q);
          end
        end
        ST_DRAIN: begin
          if (!asmi_busy && fifo_empty && (wr_count == len_q)) begin
            ld_done    <= 1'b1;
            asmi_reset <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          ld_busy <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Scoreboard bench for flash_loader: expected RAM writes are queued, a monitor checks each accepted write.
module tb_flash_loader;

  logic        clk32 = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] src_addr;
  logic [18:0] dst_addr;
  logic [16:0] length;
  logic        ld_busy, ld_done, ld_error;
  logic [23:0] asmi_addr;
  logic        asmi_rden, asmi_read, asmi_reset;
  logic        asmi_busy;
  logic        asmi_data_valid;
  logic [7:0]  asmi_dataout;
  logic        ram_req;
  logic [18:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_ack;

  always #5 clk32 = ~clk32;

  flash_loader dut (
    .clk32           (clk32),
    .rst_n           (rst_n),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .length          (length),
    .ld_busy         (ld_busy),
    .ld_done         (ld_done),
    .ld_error        (ld_error),
    .asmi_addr       (asmi_addr),
    .asmi_rden       (asmi_rden),
    .asmi_read       (asmi_read),
    .asmi_reset      (asmi_reset),
    .asmi_busy       (asmi_busy),
    .asmi_data_valid (asmi_data_valid),
    .asmi_dataout    (asmi_dataout),
    .ram_req         (ram_req),
    .ram_addr        (ram_addr),
    .ram_data        (ram_data),
    .ram_ack         (ram_ack)
  );

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  done_exp    = 0;
  int  compared    = 0;
  int  mismatched  = 0;
  int  wr_seen     = 0;
  int  read_pulses = 0;
  int  done_pulses = 0;
  int  bytes_given = 0;
  logic const_valid = 1'b0;
  logic ack_en      = 1'b1;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return (a[7:0] + 8'h3C) ^ a[15:8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Flash IP model: streams bytes from the commanded address while rden (or always, if const_valid).
  initial begin : flash_model
    logic [23:0] a;
    logic        on;
    a = '0;
    on = 1'b0;
    asmi_data_valid = 1'b0;
    asmi_dataout    = 8'h00;
    forever begin
      @(posedge clk32); #1;
      if (!rst_n || ld_done) on = 1'b0;
      if (rst_n && asmi_read) begin
        on = 1'b1;
        a  = asmi_addr;
      end
      if (on && (const_valid || asmi_rden)) begin
        asmi_data_valid = 1'b1;
        asmi_dataout    = fbyte(a);
        a               = a + 24'd1;
        bytes_given++;
      end else begin
        asmi_data_valid = 1'b0;
      end
    end
  end

  initial begin : ram_model
    ram_ack = 1'b0;
    forever begin
      @(posedge clk32); #1;
      ram_ack = ack_en && ram_req;
    end
  end

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk32);
      if (rst_n) begin
        if (ram_req && ram_ack) begin
          wr_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(ram_addr), 32'h7FFFFFFF);
          end else begin
            e = exp_q.pop_front();
            check("ram_addr", 32'(ram_addr), 32'(e.addr));
            check("ram_data", 32'(ram_data), 32'(e.data));
          end
        end
        if (asmi_read) read_pulses++;
        if (ld_done) begin
          done_pulses++;
          check("ld_done_expected", 32'(done_exp > 0), 32'd1);
          if (done_exp > 0) done_exp--;
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [23:0] s, input logic [18:0] d, input logic [16:0] n);
    @(posedge clk32); #1;
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    @(posedge clk32); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (ld_busy && k < budget) begin
      @(posedge clk32); #1;
      k++;
    end
    check({name, "_idle"}, 32'(ld_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_asmi_rden"},  32'(asmi_rden),  32'd0);
    check({tag, "_asmi_read"},  32'(asmi_read),  32'd0);
    check({tag, "_asmi_reset"}, 32'(asmi_reset), 32'd1);
    check({tag, "_ram_req"},    32'(ram_req),    32'd0);
    check({tag, "_ld_busy"},    32'(ld_busy),    32'd0);
    check({tag, "_ld_done"},    32'(ld_done),    32'd0);
    check({tag, "_ld_error"},   32'(ld_error),   32'd0);
    check({tag, "_asmi_addr"},  32'(asmi_addr),  32'd0);
    check({tag, "_ram_addr"},   32'(ram_addr),   32'd0);
  endtask

  task automatic queue_block(input logic [23:0] s, input logic [18:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({19'(d + 19'(i)), fbyte(s + 24'(i))});
  endtask

  initial begin : stimulus
    int r0, d0, w0, b0, k;
    rst_n     = 1'b0;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    length    = '0;
    asmi_busy = 1'b0;
    #12;
    check_reset_outputs("por");
    repeat (3) @(posedge clk32);
    #1 rst_n = 1'b1;

    // Basic 4-byte copy, hand-computed flash bytes 0x3C..0x3F.
    exp_q.push_back({19'h00100, 8'h3C});
    exp_q.push_back({19'h00101, 8'h3D});
    exp_q.push_back({19'h00102, 8'h3E});
    exp_q.push_back({19'h00103, 8'h3F});
    done_exp++;
    r0 = read_pulses; d0 = done_pulses; w0 = wr_seen;
    do_start(24'h010000, 19'h00100, 17'd4);
    check("t1_busy", 32'(ld_busy), 32'd1);
    wait_idle("t1", 200);
    check("t1_reads",  32'(read_pulses - r0), 32'd1);
    check("t1_dones",  32'(done_pulses - d0), 32'd1);
    check("t1_writes", 32'(wr_seen - w0),     32'd4);

    // Zero length: done on the cycle after start, no flash or RAM activity.
    r0 = read_pulses; w0 = wr_seen; d0 = done_pulses;
    done_exp++;
    @(posedge clk32); #1;
    length = 17'd0; start = 1'b1;
    @(posedge clk32); #1;
    start = 1'b0;
    check("t2_done_pulse", 32'(ld_done), 32'd1);
    check("t2_busy",       32'(ld_busy), 32'd1);
    check("t2_asmi_reset", 32'(asmi_reset), 32'd1);
    @(posedge clk32); #1;
    check("t2_done_low", 32'(ld_done), 32'd0);
    check("t2_idle",     32'(ld_busy), 32'd0);
    check("t2_reads",    32'(read_pulses - r0), 32'd0);
    check("t2_writes",   32'(wr_seen - w0),     32'd0);
    check("t2_dones",    32'(done_pulses - d0), 32'd1);

    // RAM stalled: read side throttles at two buffered bytes; RAM address wraps.
    ack_en = 1'b0;
    queue_block(24'h020080, 19'h7FFF8, 16);
    done_exp++;
    w0 = wr_seen; b0 = bytes_given;
    do_start(24'h020080, 19'h7FFF8, 17'd16);
    repeat (20) @(posedge clk32);
    #1;
    check("t3_rden_throttled", 32'(asmi_rden), 32'd0);
    check("t3_bytes_buffered", 32'(bytes_given - b0), 32'd2);
    check("t3_req_held",       32'(ram_req), 32'd1);
    check("t3_addr_held",      32'(ram_addr), 32'h7FFF8);
    ack_en = 1'b1;
    wait_idle("t3", 400);
    check("t3_error",  32'(ld_error), 32'd0);
    check("t3_writes", 32'(wr_seen - w0), 32'd16);

    // Constant-valid flash: surplus bytes beyond length are discarded.
    const_valid = 1'b1;
    queue_block(24'h0000FE, 19'h12345, 3);
    done_exp++;
    w0 = wr_seen;
    do_start(24'h0000FE, 19'h12345, 17'd3);
    wait_idle("t4", 200);
    const_valid = 1'b0;
    check("t4_writes", 32'(wr_seen - w0), 32'd3);
    check("t4_error",  32'(ld_error), 32'd0);

    // Reset mid-transfer: immediate reset values, no done, then a clean rerun.
    queue_block(24'h030000, 19'h00200, 10);
    w0 = wr_seen; d0 = done_pulses;
    do_start(24'h030000, 19'h00200, 17'd10);
    k = 0;
    while ((wr_seen - w0) < 5 && k < 200) begin
      @(posedge clk32); #1;
      k++;
    end
    check("t5_reached_five", 32'((wr_seen - w0) >= 5), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    exp_q.delete();
    repeat (2) @(posedge clk32);
    #1 rst_n = 1'b1;
    check("t5_no_done", 32'(done_pulses - d0), 32'd0);
    queue_block(24'h030000, 19'h00200, 10);
    done_exp++;
    w0 = wr_seen;
    do_start(24'h030000, 19'h00200, 17'd10);
    wait_idle("t5b", 300);
    check("t5b_writes", 32'(wr_seen - w0), 32'd10);

    // Flash busy on entry to CMD: read strobe waits for busy to clear, then fires once.
    asmi_busy = 1'b1;
    queue_block(24'h0400F0, 19'h00040, 2);
    done_exp++;
    r0 = read_pulses;
    do_start(24'h0400F0, 19'h00040, 17'd2);
    repeat (8) @(posedge clk32);
    #1;
    check("t6_read_held", 32'(read_pulses - r0), 32'd0);
    check("t6_rden_setup", 32'(asmi_rden), 32'd1);
    asmi_busy = 1'b0;
    wait_idle("t6", 200);
    check("t6_reads", 32'(read_pulses - r0), 32'd1);

    repeat (3) @(posedge clk32);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_pending", 32'(done_exp), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
